mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Data-memory access stage sitting between execute and writeback.
- Takes the ALU-computed address, store data and load/store controls.
- Runs a req/gnt/rvalid handshake with data memory.
- Produces the aligned, sign/zero-extended load result consumed by writeback as memory_data_i.
- Stalls the pipeline while a memory transaction is outstanding.

Parameters:
DWIDTH, DATA_WIDTH (32), data path width; byte lanes = DWIDTH/8.
AWIDTH, ADDR_WIDTH (32), address width.
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before abort.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
valid_i  input  1  execute-stage instruction valid
memren_i  input  1  instruction is a load
memwen_i  input  1  instruction is a store (priority over memren_i if both set)
funct3_i  input  3  access size/sign (RV32I encoding)
addr_i  input  AWIDTH  effective byte address (ALU result)
store_data_i  input  DWIDTH  rs2 value
stall_o  output  1  hold upstream stages
dmem_req_o  output  1  bus request
dmem_we_o  output  1  bus write enable
dmem_addr_o  output  AWIDTH  word-aligned address (addr[1:0]=0)
dmem_wdata_o  output  DWIDTH  lane-replicated store data
dmem_be_o  output  DWIDTH/8  byte enables
dmem_gnt_i  input  1  request accepted
dmem_rvalid_i  input  1  read data valid
dmem_rdata_i  input  DWIDTH  read word
memory_data_o  output  DWIDTH  extended load result to writeback
done_o  output  1  one-cycle pulse: access finished (any outcome)
misaligned_o  output  1  one-cycle pulse with done_o: misaligned access, no bus activity
timeout_o  output  1  one-cycle pulse with done_o: bus timeout

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; all outputs 0; timeout counter 0. Applies mid-transaction: dmem_req_o drops next cycle and the pending access is discarded.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, valid_i & (memren_i|memwen_i):
  - Latch op, size, addr, data.
  - Aligned -> REQ. Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP with misaligned_o set.
  - Non-memory valid instructions pass with no stall and no done_o.
- REQ:
  - dmem_req_o=1; addr/we/wdata/be held stable until dmem_gnt_i.
  - gnt & store -> RESP. gnt & load -> WAIT.
  - dmem_req_o deasserts the cycle after gnt.
- WAIT:
  - On dmem_rvalid_i, extract and extend, register into memory_data_o, then -> RESP.
  - rvalid is guaranteed no earlier than the cycle after gnt. An rvalid seen in IDLE/REQ is ignored.
- RESP: done_o=1 (plus misaligned_o/timeout_o if applicable) for exactly one cycle, then -> IDLE.
- stall_o = (IDLE & valid_i & mem op) | REQ | WAIT. stall_o is 0 in RESP, so the next instruction advances in the same cycle done_o is high.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES-1 without completion -> RESP with timeout_o=1 and memory_data_o=0.
  - Late gnt/rvalid after that point is ignored.
- Byte enables:
  - SB: 0001<<addr[1:0].
  - SH: 0011<<(2*addr[1]).
  - SW: 1111.
- Write data: SB replicates byte x4; SH replicates half x2; SW passes through.
- Load extraction, lane selected by latched addr[1:0]:
  - LB: sign-extend.
  - LBU: zero-extend.
  - LH: sign-extend half at addr[1].
  - LHU: zero-extend half at addr[1].
  - LW: whole word.
- Undefined funct3 is treated as word access.
- memory_data_o holds its value until the next completed load, misalignment or timeout; stores do not change it.
- Latency, zero-wait bus (gnt same cycle as req, rvalid next cycle): load = 4 cycles valid_i->done_o; store = 3 cycles.

Decomposition:
- Shared package: FSM state enum, funct3 size codes (LB/LH/LW/LBU/LHU/SB/SH/SW), byte-lane count, and the TIMEOUT_CYCLES default.
- One natural sub-module: load_extend, purely combinational (rdata, addr[1:0], funct3 -> extended word), reused for lane/extension checks in the bench.

Test Plan:
- LB at 0x1003, rdata=0x80FF_0000 -> be=0000 (load), memory_data_o=0xFFFF_FF80; same with LBU -> 0x0000_0080; done_o 1 pulse.
- SH at 0x2002, data=0x1234_ABCD -> dmem_addr_o=0x2000, be=1100, wdata=0xABCD_ABCD, we=1; done_o 1 cycle after gnt; memory_data_o unchanged.
- LW at 0x3001 -> no dmem_req_o ever; done_o and misaligned_o together 2 cycles after valid; stall_o 1 for one cycle only.
- gnt withheld 5 cycles -> addr/be/wdata stable all 5 cycles; rvalid with 0xDEAD_BEEF -> LW result 0xDEAD_BEEF.
- No gnt for 16 cycles -> timeout_o and done_o pulse, memory_data_o=0, FSM back to IDLE; a later gnt is ignored.
- reset=0 asserted in WAIT -> next cycle all outputs 0 and state IDLE; a following rvalid has no effect.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access stage.
package mem_access_unit_pkg;

  localparam int unsigned DATA_WIDTH             = 32;
  localparam int unsigned ADDR_WIDTH             = 32;
  localparam int unsigned NUM_LANES              = DATA_WIDTH / 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Undefined encodings fall back to a full-word access.
  function automatic size_t access_size(input logic is_store, input logic [2:0] funct3);
    size_t sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter  int unsigned DWIDTH = DATA_WIDTH,
  localparam int unsigned OFF_W  = $clog2(DWIDTH / 8)
) (
  input  logic [DWIDTH-1:0] rdata,
  input  logic [OFF_W-1:0]  offset,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] ext_data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane  = 8'(rdata >> {offset, 3'b000});
    half_lane  = 16'(rdata >> {offset[OFF_W-1:1], 4'b0000});
    ext_data_c = rdata;
    case (funct3)
      F3_LB:   ext_data_c = {{(DWIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  ext_data_c = {{(DWIDTH-8){1'b0}}, byte_lane};
      F3_LH:   ext_data_c = {{(DWIDTH-16){half_lane[15]}}, half_lane};
      F3_LHU:  ext_data_c = {{(DWIDTH-16){1'b0}}, half_lane};
      default: ext_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: req/gnt/rvalid bus handshake, lane steering,
// load extension, misalignment detection and bus timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DWIDTH         = DATA_WIDTH,
  parameter int unsigned AWIDTH         = ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                memren_i,
  input  logic                memwen_i,
  input  logic [2:0]          funct3_i,
  input  logic [AWIDTH-1:0]   addr_i,
  input  logic [DWIDTH-1:0]   store_data_i,
  output logic                stall_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [AWIDTH-1:0]   dmem_addr_o,
  output logic [DWIDTH-1:0]   dmem_wdata_o,
  output logic [DWIDTH/8-1:0] dmem_be_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [DWIDTH-1:0]   dmem_rdata_i,
  output logic [DWIDTH-1:0]   memory_data_o,
  output logic                done_o,
  output logic                misaligned_o,
  output logic                timeout_o
);

  localparam int unsigned LANES = DWIDTH / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [OFF_W-1:0]   off_q, off_d;

  logic               req_d, dwe_d, done_d, mis_d, tmo_d;
  logic [AWIDTH-1:0]  addr_d;
  logic [DWIDTH-1:0]  wdata_d, mem_data_d;
  logic [LANES-1:0]   be_d;

  logic               mem_op_c;
  size_t              size_c;
  logic               misaligned_c;
  logic               timeout_hit_c;
  logic [LANES-1:0]   be_c;
  logic [DWIDTH-1:0]  wdata_c;
  logic [DWIDTH-1:0]  ext_data_c;

  assign mem_op_c      = memren_i | memwen_i;
  assign size_c        = access_size(memwen_i, funct3_i);
  assign misaligned_c  = ((size_c == SZ_HALF) && addr_i[0]) ||
                         ((size_c == SZ_WORD) && (addr_i[OFF_W-1:0] != '0));
  assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign stall_o = ((state_q == ST_IDLE) && valid_i && mem_op_c) ||
                   (state_q == ST_REQ) || (state_q == ST_WAIT);

  // Store lane steering from the incoming address and size.
  always_comb begin
    be_c    = '1;
    wdata_c = store_data_i;
    case (size_c)
      SZ_BYTE: begin
        be_c    = LANES'(1) << addr_i[OFF_W-1:0];
        wdata_c = {LANES{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_c    = LANES'(3) << {addr_i[OFF_W-1:1], 1'b0};
        wdata_c = {(LANES/2){store_data_i[15:0]}};
      end
      default: begin
        be_c    = '1;
        wdata_c = store_data_i;
      end
    endcase
  end

  mem_access_unit_load_extend #(
    .DWIDTH (DWIDTH)
  ) u_load_extend (
    .rdata      (dmem_rdata_i),
    .offset     (off_q),
    .funct3     (funct3_q),
    .ext_data_c (ext_data_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    req_d      = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    tmo_d      = 1'b0;
    mem_data_d = memory_data_o;
    addr_d     = dmem_addr_o;
    dwe_d      = dmem_we_o;
    wdata_d    = dmem_wdata_o;
    be_d       = dmem_be_o;

    case (state_q)
      ST_IDLE: begin
        if (valid_i && mem_op_c) begin
          we_d     = memwen_i;
          funct3_d = funct3_i;
          off_d    = addr_i[OFF_W-1:0];
          if (misaligned_c) begin
            state_d    = ST_RESP;
            done_d     = 1'b1;
            mis_d      = 1'b1;
            mem_data_d = '0;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            cnt_d   = '0;
            addr_d  = {addr_i[AWIDTH-1:OFF_W], OFF_W'(0)};
            dwe_d   = memwen_i;
            be_d    = memwen_i ? be_c : '0;
            wdata_d = memwen_i ? wdata_c : '0;
          end
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        req_d = 1'b1;
        if (dmem_gnt_i && we_q) begin
          state_d = ST_RESP;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end else if (timeout_hit_c) begin
          state_d    = ST_RESP;
          req_d      = 1'b0;
          done_d     = 1'b1;
          tmo_d      = 1'b1;
          mem_data_d = '0;
        end else if (dmem_gnt_i) begin
          state_d = ST_WAIT;
          req_d   = 1'b0;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid_i) begin
          state_d    = ST_RESP;
          done_d     = 1'b1;
          mem_data_d = ext_data_c;
        end else if (timeout_hit_c) begin
          state_d    = ST_RESP;
          done_d     = 1'b1;
          tmo_d      = 1'b1;
          mem_data_d = '0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= '0;
      dmem_wdata_o  <= '0;
      dmem_be_o     <= '0;
      memory_data_o <= '0;
      done_o        <= 1'b0;
      misaligned_o  <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      dmem_req_o    <= req_d;
      dmem_we_o     <= dwe_d;
      dmem_addr_o   <= addr_d;
      dmem_wdata_o  <= wdata_d;
      dmem_be_o     <= be_d;
      memory_data_o <= mem_data_d;
      done_o        <= done_d;
      misaligned_o  <= mis_d;
      timeout_o     <= tmo_d;
    end
  end

endmodule
